// File: rtl/switch_pre_feed.sv
// switch_pre_feed: pops one store-and-forward frame from the FWFT descriptor
// and byte FIFOs and streams it to switch_pre as a 2-byte header, the frame
// bytes, then zero padding up to the next 16-byte cell boundary.
module switch_pre_feed #(
   parameter int MIN_LEN = 60,
   parameter int MAX_LEN = 1518
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] ptr_fifo_dout,
   input  logic        ptr_fifo_empty,
   output logic        ptr_fifo_rd,
   input  logic [7:0]  data_fifo_dout,
   input  logic        data_fifo_empty,
   output logic        data_fifo_rd,
   output logic        sof,
   output logic        dv,
   output logic [7:0]  dout,
   input  logic        i_cell_bp,
   output logic        busy,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt,
   output logic        underrun
);

   localparam logic [10:0] MIN_L = 11'(MIN_LEN);
   localparam logic [10:0] MAX_L = 11'(MAX_LEN);

   typedef enum logic [2:0] {IDLE, CHECK, SOF, BODY, GAP, DROP} state_t;

   state_t      state, state_n;
   logic [3:0]  portmap_q, portmap_n;
   logic [10:0] len_q, len_n;
   logic [11:0] idx, idx_n;
   logic        sof_n, dv_n, ptr_rd_n, underrun_n;
   logic [7:0]  dout_n;
   logic [15:0] frame_cnt_n, drop_cnt_n;

   logic [11:0] total;
   logic [7:0]  byte0, byte1;
   logic        frame_due, drop_due;
   logic        unused_desc_bit11;

   // Descriptor bit 11 carries no meaning for this block.
   assign unused_desc_bit11 = ptr_fifo_dout[11];

   // Header bytes and the cell-rounded stream length of the latched frame.
   assign byte0 = {1'b0, len_q[10:8], portmap_q};
   assign byte1 = len_q[7:0];
   assign total = ({1'b0, len_q} + 12'd17) & 12'hFF0;

   // A frame byte is due when the next stream index lands inside the frame;
   // a drop pop is due until len bytes have been discarded.
   assign frame_due = (state == BODY) && (idx != total - 12'd1) && (idx <= {1'b0, len_q});
   assign drop_due  = (state == DROP) && (idx != {1'b0, len_q});

   assign data_fifo_rd = (frame_due || drop_due) && !data_fifo_empty;
   assign busy         = (state != IDLE);

   // Next-state and next registered-output logic.
   always_comb begin
      state_n     = state;
      portmap_n   = portmap_q;
      len_n       = len_q;
      idx_n       = idx;
      sof_n       = sof;
      dv_n        = dv;
      dout_n      = dout;
      ptr_rd_n    = 1'b0;
      underrun_n  = 1'b0;
      frame_cnt_n = frame_cnt;
      drop_cnt_n  = drop_cnt;
      case (state)
         IDLE: begin
            sof_n  = 1'b0;
            dv_n   = 1'b0;
            dout_n = 8'h00;
            if (!ptr_fifo_empty) begin
               portmap_n = ptr_fifo_dout[15:12];
               len_n     = ptr_fifo_dout[10:0];
               ptr_rd_n  = 1'b1;
               state_n   = CHECK;
            end
         end
         CHECK: begin
            if ((len_q >= MIN_L) && (len_q <= MAX_L)) begin
               sof_n   = 1'b1;
               dv_n    = 1'b1;
               dout_n  = byte0;
               state_n = SOF;
            end else begin
               drop_cnt_n = drop_cnt + 16'd1;
               idx_n      = 12'd0;
               state_n    = DROP;
            end
         end
         SOF: begin
            if (!i_cell_bp) begin
               sof_n   = 1'b0;
               dout_n  = byte1;
               idx_n   = 12'd1;
               state_n = BODY;
            end
         end
         BODY: begin
            if (idx == total - 12'd1) begin
               dv_n    = 1'b0;
               dout_n  = 8'h00;
               state_n = GAP;
            end else begin
               idx_n = idx + 12'd1;
               if (frame_due) begin
                  if (data_fifo_empty) begin
                     dout_n     = 8'h00;
                     underrun_n = 1'b1;
                  end else begin
                     dout_n = data_fifo_dout;
                  end
               end else begin
                  dout_n = 8'h00;
               end
            end
         end
         GAP: begin
            frame_cnt_n = frame_cnt + 16'd1;
            state_n     = IDLE;
         end
         DROP: begin
            if (drop_due) begin
               idx_n      = idx + 12'd1;
               underrun_n = data_fifo_empty;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any frame in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         portmap_q   <= 4'd0;
         len_q       <= 11'd0;
         idx         <= 12'd0;
         sof         <= 1'b0;
         dv          <= 1'b0;
         dout        <= 8'h00;
         ptr_fifo_rd <= 1'b0;
         underrun    <= 1'b0;
         frame_cnt   <= 16'd0;
         drop_cnt    <= 16'd0;
      end else begin
         state       <= state_n;
         portmap_q   <= portmap_n;
         len_q       <= len_n;
         idx         <= idx_n;
         sof         <= sof_n;
         dv          <= dv_n;
         dout        <= dout_n;
         ptr_fifo_rd <= ptr_rd_n;
         underrun    <= underrun_n;
         frame_cnt   <= frame_cnt_n;
         drop_cnt    <= drop_cnt_n;
      end
   end

endmodule

// File: tb/tb_switch_pre_feed.sv
// tb_switch_pre_feed: drives switch_pre_feed from modelled FWFT FIFOs and
// compares the emitted byte stream with a frame-level reference model.
module tb_switch_pre_feed;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] ptr_fifo_dout;
   logic        ptr_fifo_empty;
   logic        ptr_fifo_rd;
   logic [7:0]  data_fifo_dout;
   logic        data_fifo_empty;
   logic        data_fifo_rd;
   logic        sof, dv;
   logic [7:0]  dout;
   logic        i_cell_bp = 1'b0;
   logic        busy;
   logic [15:0] frame_cnt, drop_cnt;
   logic        underrun;

   logic        force_empty = 1'b0;
   logic [15:0] dmem [0:15];
   logic [7:0]  bmem [0:8191];
   logic [3:0]  dwr = '0, drd = '0;
   logic [12:0] bwr = '0, brd = '0;

   logic [7:0]  cap [$];
   logic [7:0]  exp [$];
   logic [7:0]  last_pay [$];
   int pops = 0, sof_pops = 0, sof_cycles = 0, underruns = 0;
   int low_run = 0, last_gap = 0;
   int mod_frames = 0, mod_drops = 0, mod_pops = 0;
   int compared = 0, mismatched = 0;

   switch_pre_feed dut (
      .clk(clk), .rstn(rstn),
      .ptr_fifo_dout(ptr_fifo_dout), .ptr_fifo_empty(ptr_fifo_empty), .ptr_fifo_rd(ptr_fifo_rd),
      .data_fifo_dout(data_fifo_dout), .data_fifo_empty(data_fifo_empty), .data_fifo_rd(data_fifo_rd),
      .sof(sof), .dv(dv), .dout(dout), .i_cell_bp(i_cell_bp), .busy(busy),
      .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .underrun(underrun)
   );

   always #5 clk = ~clk;

   assign ptr_fifo_empty  = (drd == dwr);
   assign ptr_fifo_dout   = dmem[drd];
   assign data_fifo_empty = (brd == bwr) || force_empty;
   assign data_fifo_dout  = bmem[brd];

   // FIFO heads advance on each edge that pops them.
   always @(posedge clk) begin
      if (ptr_fifo_rd) drd <= drd + 4'd1;
      if (data_fifo_rd) brd <= brd + 13'd1;
   end

   // Stream monitor: records accepted bytes, pops, pulses and inter-frame gaps.
   always @(negedge clk) begin
      if (dv && (!sof || !i_cell_bp)) cap.push_back(dout);
      if (dv && sof) sof_cycles++;
      if (data_fifo_rd) pops++;
      if (data_fifo_rd && sof) sof_pops++;
      if (underrun) underruns++;
      if (dv) begin
         if (sof && low_run != 0) last_gap = low_run;
         low_run = 0;
      end else begin
         low_run++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Queue one frame (bytes first, then descriptor) and extend the model.
   task automatic applyStimulus(input int len, input logic [3:0] pm, input bit rnd);
      logic [15:0] d;
      logic [7:0]  b;
      int          start, total;
      last_pay.delete();
      for (int i = 0; i < len; i++) begin
         b = rnd ? 8'($urandom) : 8'(i);
         bmem[bwr] = b;
         bwr = bwr + 13'd1;
         last_pay.push_back(b);
      end
      d = {pm, 1'($urandom_range(0, 1)), 11'(len)};
      dmem[dwr] = d;
      dwr = dwr + 4'd1;
      mod_pops += len;
      if (len >= 60 && len <= 1518) begin
         start = exp.size();
         total = ((len + 2 + 15) / 16) * 16;
         exp.push_back(8'((len / 256) * 16 + int'(pm)));
         exp.push_back(8'(len % 256));
         foreach (last_pay[i]) exp.push_back(last_pay[i]);
         while (exp.size() - start < total) exp.push_back(8'h00);
         mod_frames++;
      end else begin
         mod_drops++;
      end
   endtask

   task automatic waitIdle(input string tag, input int budget, input bit randbp);
      int n = 0;
      bit done = 0;
      while (!done && n < budget) begin
         @(posedge clk); #1;
         if (randbp) i_cell_bp = 1'($urandom_range(0, 1));
         n++;
         if (!busy && drd == dwr && !ptr_fifo_rd) done = 1;
      end
      i_cell_bp = 1'b0;
      checkOutput({tag, " completes"}, 32'(done), 32'd1);
   endtask

   task automatic waitSof(input string tag, input int budget);
      int n = 0;
      bit seen = 0;
      while (!seen && n < budget) begin
         @(posedge clk); #1;
         n++;
         if (dv && sof) seen = 1;
      end
      checkOutput({tag, " sof seen"}, 32'(seen), 32'd1);
   endtask

   task automatic compareStream(input string tag, input int base);
      int bad = -1;
      int n;
      n = cap.size() - base;
      checkOutput({tag, " stream length"}, 32'(n), 32'(exp.size()));
      for (int i = 0; i < n && i < exp.size(); i++)
         if (bad < 0 && cap[base + i] !== exp[i]) bad = i;
      checkOutput({tag, " first wrong byte index"}, 32'(bad), 32'hFFFF_FFFF);
   endtask

   initial begin
      int base, p0, s0, u0, sp0, len;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset sof", 32'(sof), 32'd0);
      checkOutput("reset dv", 32'(dv), 32'd0);
      checkOutput("reset dout", 32'(dout), 32'd0);
      checkOutput("reset ptr_fifo_rd", 32'(ptr_fifo_rd), 32'd0);
      checkOutput("reset counters", {frame_cnt, drop_cnt}, 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      rstn = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Minimum frame
      $display("[TB] minimum frame");
      exp.delete(); base = cap.size(); p0 = pops;
      applyStimulus(60, 4'b0010, 1'b0);
      waitIdle("t1", 500, 1'b0);
      compareStream("t1", base);
      checkOutput("t1 frame_cnt", 32'(frame_cnt), 32'(mod_frames));
      checkOutput("t1 pops", 32'(pops - p0), 32'd60);

      // Maximum frame, no padding
      $display("[TB] maximum frame");
      exp.delete(); base = cap.size(); p0 = pops;
      applyStimulus(1518, 4'b1000, 1'b1);
      waitIdle("t2", 4000, 1'b0);
      compareStream("t2", base);
      checkOutput("t2 pops", 32'(pops - p0), 32'd1518);

      // Start-of-frame backpressure
      $display("[TB] start backpressure");
      exp.delete(); base = cap.size(); p0 = pops; s0 = sof_cycles; sp0 = sof_pops;
      i_cell_bp = 1'b1;
      applyStimulus(100, 4'b0101, 1'b1);
      waitSof("t3", 20);
      repeat (10) @(posedge clk);
      #1;
      i_cell_bp = 1'b0;
      waitIdle("t3", 500, 1'b0);
      compareStream("t3", base);
      checkOutput("t3 sof hold cycles", 32'(sof_cycles - s0), 32'd11);
      checkOutput("t3 pops during sof", 32'(sof_pops - sp0), 32'd0);

      // Invalid descriptor followed by a valid one
      $display("[TB] invalid descriptor");
      exp.delete(); base = cap.size(); p0 = pops;
      applyStimulus(40, 4'b0001, 1'b1);
      applyStimulus(64, 4'b0100, 1'b1);
      waitIdle("t4", 800, 1'b0);
      compareStream("t4", base);
      checkOutput("t4 drop_cnt", 32'(drop_cnt), 32'(mod_drops));
      checkOutput("t4 pops", 32'(pops - p0), 32'd104);

      // Back-to-back frames
      $display("[TB] back-to-back");
      exp.delete(); base = cap.size();
      applyStimulus(64, 4'b0011, 1'b1);
      applyStimulus(64, 4'b1100, 1'b1);
      waitIdle("t5", 800, 1'b0);
      compareStream("t5", base);
      checkOutput("t5 gap cycles", 32'(last_gap), 32'd3);
      checkOutput("t5 frame_cnt", 32'(frame_cnt), 32'(mod_frames));

      // Randomized frames, lengths and backpressure
      $display("[TB] random frames");
      for (int r = 0; r < 12; r++) begin
         exp.delete(); base = cap.size(); p0 = pops;
         case ($urandom_range(0, 3))
            0, 1: len = int'($urandom_range(60, 260));
            2: len = int'($urandom_range(0, 59));
            default: begin
               case ($urandom_range(0, 6))
                  0: len = 59;
                  1: len = 60;
                  2: len = 61;
                  3: len = 1517;
                  4: len = 1518;
                  5: len = 1519;
                  default: len = 2047;
               endcase
            end
         endcase
         applyStimulus(len, 4'($urandom), 1'b1);
         waitIdle("rnd", 4000, 1'b1);
         compareStream("rnd", base);
         checkOutput("rnd pops", 32'(pops - p0), 32'(len));
         checkOutput("rnd counters", {frame_cnt, drop_cnt}, {16'(mod_frames), 16'(mod_drops)});
      end

      // Underrun at stream byte 20 for two cycles
      $display("[TB] underrun");
      exp.delete(); base = cap.size(); p0 = pops; u0 = underruns;
      applyStimulus(64, 4'b0110, 1'b1);
      exp[20] = 8'h00;
      exp[21] = 8'h00;
      for (int k = 22; k < 66; k++) exp[k] = last_pay[k - 4];
      waitSof("t6", 20);
      repeat (19) @(posedge clk);
      #1;
      force_empty = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      force_empty = 1'b0;
      waitIdle("t6", 500, 1'b0);
      compareStream("t6", base);
      checkOutput("t6 underrun pulses", 32'(underruns - u0), 32'd2);
      checkOutput("t6 pops", 32'(pops - p0), 32'd62);
      checkOutput("t6 frame_cnt", 32'(frame_cnt), 32'(mod_frames));

      // Reset in the middle of a frame
      $display("[TB] reset mid-frame");
      applyStimulus(200, 4'b1001, 1'b1);
      waitSof("t7", 20);
      repeat (30) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      checkOutput("t7 sof", 32'(sof), 32'd0);
      checkOutput("t7 dv", 32'(dv), 32'd0);
      checkOutput("t7 dout", 32'(dout), 32'd0);
      checkOutput("t7 counters", {frame_cnt, drop_cnt}, 32'd0);
      checkOutput("t7 busy", 32'(busy), 32'd0);
      #2;
      rstn = 1'b1;
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/switch_pre_feed.md
Name: switch_pre_feed

Overview:
- Ingress frame-to-byte-stream feeder that sits directly upstream of switch_pre.
- Pops one store-and-forward frame from the port's frame descriptor FIFO and byte FIFO, both first-word-fall-through (FWFT).
- Emits a contiguous sof/dv/byte stream: a 2-byte header, the frame, then zero padding to a 16-byte cell boundary.
- switch_pre packs this stream into 128-bit cells; this block honours switch_pre's cell-FIFO backpressure at frame start.

Parameters:
MIN_LEN, 60, smallest valid frame length in bytes
MAX_LEN, 1518, largest valid frame length in bytes

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
ptr_fifo_dout  in  16  descriptor: [15:12] portmap, [10:0] len; [11] ignored
ptr_fifo_empty  in  1  descriptor FIFO empty
ptr_fifo_rd  out  1  descriptor pop, registered one-cycle pulse
data_fifo_dout  in  8  frame byte at FIFO head
data_fifo_empty  in  1  byte FIFO empty
data_fifo_rd  out  1  byte pop, combinational from state and counters
sof  out  1  first byte of frame, to switch_pre sof
dv  out  1  byte valid, to switch_pre dv
dout  out  8  stream byte, to switch_pre din
i_cell_bp  in  1  switch_pre cell-FIFO backpressure
busy  out  1  high in every state except IDLE
frame_cnt  out  16  frames forwarded, wraps
drop_cnt  out  16  descriptors dropped, wraps
underrun  out  1  one-cycle pulse when a frame byte is needed and data_fifo_empty=1

Behaviour:
- Clock and reset: clock clk; reset rstn, asynchronous, active-low.
- Registered outputs: sof, dv, dout, ptr_fifo_rd, frame_cnt, drop_cnt, underrun. All reset to 0, and state resets to IDLE.
- Reset mid-frame: the partial frame is abandoned; switch_pre shares rstn.
- Header and size:
  - byte0 = {1'b0, len[10:8], portmap}; byte1 = len[7:0].
  - Frame bytes occupy stream bytes 2..len+1.
  - Pad bytes are 0x00 up to total = (len+17) & ~15 (12-bit arithmetic), so total is always a multiple of 16.
- IDLE: dv=0, sof=0. If ptr_fifo_empty=0, latch ptr_fifo_dout, pulse ptr_fifo_rd, go to CHECK.
- CHECK: if MIN_LEN <= len <= MAX_LEN, register sof=1, dv=1, dout=byte0 and go to SOF. Otherwise increment drop_cnt and go to DROP.
- SOF handshake (sof=1, dv=1, dout=byte0 held):
  - At each edge with i_cell_bp=0, switch_pre accepts the byte. Register sof=0, dout=byte1, idx=1, and go to BODY.
  - With i_cell_bp=1, hold all outputs; there is no timeout.
- BODY: dv=1. Each edge presents idx+1:
  - frame index (2..len+1): dout=data_fifo_dout, with data_fifo_rd=1 in the same cycle;
  - pad index: dout=0x00.
  - When idx = total-1, the next edge registers dv=0, dout=0 and goes to GAP.
  - Bytes within a frame are strictly contiguous; i_cell_bp is ignored after acceptance.
- GAP: dv=0 for one cycle, increment frame_cnt, go to IDLE.
  - Minimum spacing: 3 dv-low cycles between the last byte of one frame and the next sof.
- DROP: assert data_fifo_rd for exactly len cycles; no sof or dv is emitted. Then go to IDLE.
- Underrun:
  - Frame bytes are guaranteed present before their descriptor is written.
  - If data_fifo_empty=1 when a frame byte or DROP pop is due: substitute 0x00, do not pop, pulse underrun, keep idx advancing.
  - Cell framing is preserved; there is no further recovery.
- A descriptor write during a frame has no effect until IDLE.

Test Plan:
1. Minimum frame: len=60, portmap=4'b0010, bytes 0x00..0x3B queued -> sof with dout=0x02, then 0x3C, 0x00..0x3B, two 0x00 pads. 64 dv cycles total, then dv=0; frame_cnt=1, 60 pops.
2. Maximum frame, no pad: len=1518, portmap=4'b1000 -> byte0=0x58, byte1=0xEE, 1520 dv cycles (95 cells), no pad bytes.
3. Start backpressure: len=100 with i_cell_bp=1 for 10 cycles from the start of the SOF state -> sof=1 and dout=byte0 held 11 cycles, no data pops. Byte1 appears the cycle after the first edge with i_cell_bp=0; 112 dv cycles total.
4. Invalid descriptor: len=40, 40 bytes queued, then a valid len=64 descriptor -> no sof for the first, 40 pops, drop_cnt=1. The second frame is sent intact: 80 bytes, first frame byte equal to the first byte of the 64-byte frame.
5. Back-to-back: two len=64 descriptors queued -> exactly 3 dv=0 cycles between the last byte of frame 1 and sof of frame 2; frame_cnt=2.
6. Underrun and reset: force data_fifo_empty=1 at stream byte 20 for 2 cycles -> dout=0x00 twice, underrun pulses twice, frame length unchanged. Then assert rstn=0 mid-frame -> sof, dv, dout, and the counters go to 0 immediately; busy goes to 0.
